// File: rtl/matmul_pool_engine.sv
// matmul_pool_engine: C = A*B over NxN unsigned bytes read from memory, then 2x2/stride-2
// max or average pooling, saturated to 8 bits and written back four results per word.
module matmul_pool_engine #(
   parameter int                N      = 4,
   parameter int                ADDR_W = 10,
   parameter logic [ADDR_W-1:0] A_BASE = 10'h000,
   parameter logic [ADDR_W-1:0] B_BASE = 10'h100,
   parameter logic [ADDR_W-1:0] C_BASE = 10'h200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              kick_start,
   input  logic              pool_mode,
   output logic              ready,
   output logic              done,
   output logic              mem_en_read_A,
   output logic [ADDR_W-1:0] mem_addr_A,
   input  logic [31:0]       mem_data_A,
   output logic              mem_en_read_B,
   output logic [ADDR_W-1:0] mem_addr_B,
   input  logic [31:0]       mem_data_B,
   output logic              mem_en_write_C,
   output logic [ADDR_W-1:0] mem_addr_C,
   output logic [31:0]       mem_data_C
);
   localparam int NE    = N * N;
   localparam int W     = NE / 4;
   localparam int NP    = N / 2;
   localparam int P_W   = NE / 16;
   localparam int ACC_W = 16 + $clog2(N);
   localparam int CNT_W = $clog2(NE + 1);
   localparam int IDX_W = $clog2(N);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_COMPUTE = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rd_idx;
   logic [IDX_W-1:0] cr, cc;
   logic             mode_q;
   logic             rd_valid;
   logic             rd_en;
   logic             wr_en;
   logic [ACC_W-1:0] dot;
   logic [31:0]      wr_word;

   logic [7:0]       a_buf  [NE];
   logic [7:0]       b_buf  [NE];
   logic [ACC_W-1:0] c_buf  [NE];
   logic [7:0]       pooled [NP*NP];

   function automatic logic [7:0] pool4(input logic [ACC_W-1:0] v0, v1, v2, v3,
                                        input logic avg);
      logic [ACC_W-1:0] m01, m23;
      logic [ACC_W+1:0] sum, res;
      m01 = (v0 > v1) ? v0 : v1;
      m23 = (v2 > v3) ? v2 : v3;
      sum = (ACC_W+2)'(v0) + (ACC_W+2)'(v1) + (ACC_W+2)'(v2) + (ACC_W+2)'(v3);
      if (avg) res = sum >> 2;
      else     res = (ACC_W+2)'((m01 > m23) ? m01 : m23);
      return (res > (ACC_W+2)'(255)) ? 8'hFF : res[7:0];
   endfunction

   assign ready = (state == S_IDLE);
   assign done  = (state == S_DONE);
   assign rd_en = (state == S_LOAD) && (cnt < CNT_W'(W));
   assign wr_en = (state == S_WRITE);

   // Address and data buses are forced to zero whenever their strobe is idle.
   assign mem_en_read_A  = rd_en;
   assign mem_en_read_B  = rd_en;
   assign mem_addr_A     = rd_en ? A_BASE + ADDR_W'(cnt) : '0;
   assign mem_addr_B     = rd_en ? B_BASE + ADDR_W'(cnt) : '0;
   assign mem_en_write_C = wr_en;
   assign mem_addr_C     = wr_en ? C_BASE + ADDR_W'(cnt) : '0;
   assign mem_data_C     = wr_en ? wr_word : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         rd_idx   <= '0;
         cr       <= '0;
         cc       <= '0;
         mode_q   <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         rd_idx   <= cnt;
         case (state)
            S_IDLE: if (kick_start) begin
               state  <= S_LOAD;
               cnt    <= '0;
               mode_q <= pool_mode;
            end
            // Count runs one past the last read to leave a drain cycle for the final capture.
            S_LOAD: if (cnt == CNT_W'(W)) begin
               state <= S_COMPUTE;
               cnt   <= '0;
               cr    <= '0;
               cc    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            S_COMPUTE: begin
               if (cc == IDX_W'(N - 1)) begin
                  cc <= '0;
                  cr <= cr + 1'b1;
               end else begin
                  cc <= cc + 1'b1;
               end
               if (cnt == CNT_W'(NE - 1)) begin
                  state <= S_WRITE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WRITE: if (cnt == CNT_W'(P_W - 1)) begin
               state <= S_DONE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: the buffers have no reset; each run rewrites every entry before it is read.
   always_ff @(posedge clk) begin
      if (rd_valid) begin
         for (int b = 0; b < 4; b++) begin
            a_buf[4*int'(rd_idx) + b] <= mem_data_A[8*b +: 8];
            b_buf[4*int'(rd_idx) + b] <= mem_data_B[8*b +: 8];
         end
      end
      if (state == S_COMPUTE) c_buf[int'(cr)*N + int'(cc)] <= dot;
   end

   always_comb begin
      dot = '0;
      for (int k = 0; k < N; k++)
         dot = dot + ACC_W'(a_buf[int'(cr)*N + k]) * ACC_W'(b_buf[k*N + int'(cc)]);
   end

   always_comb begin
      for (int p = 0; p < NP*NP; p++)
         pooled[p] = pool4(c_buf[2*(p/NP)*N + 2*(p%NP)],
                           c_buf[2*(p/NP)*N + 2*(p%NP) + 1],
                           c_buf[2*(p/NP)*N + 2*(p%NP) + N],
                           c_buf[2*(p/NP)*N + 2*(p%NP) + N + 1],
                           mode_q);
   end

   always_comb begin
      wr_word = '0;
      for (int b = 0; b < 4; b++)
         if (4*int'(cnt) + b < NP*NP) wr_word[8*b +: 8] = pooled[4*int'(cnt) + b];
   end
endmodule
